rt_result_writer: RTL and testbench

Raytracer result write-back engine on `sdr_clk`:
- Accepts a stream of 32-bit result words from the raytracing core and packs them into 2048-bit chunks.
- Hands each chunk to the SDRAM write bridge over the `sdr_writestart`/`sdr_writeend` handshake, placing chunk k at `base + k*256` bytes.
- After the last chunk is written, pulses `end_rt` with a status code back to the HPS.

It is the write-direction counterpart of the ray-fetch FSM that drives `sdr_readstart`/`sdr_readend`.

---
 rtl/rt_sdr_pkg.sv | 25 ++
 rtl/rt_chunk_packer.sv | 42 ++++
 rtl/rt_result_writer.sv | 157 +++++++++++++++
 tb/tb_rt_result_writer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_sdr_pkg.sv
// Shared constants and types for the raytracer SDRAM write path.
package rt_sdr_pkg;

  localparam int WORD_W      = 32;
  localparam int CHUNK_WORDS = 64;
  localparam int CHUNK_BYTES = 256;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_FILL  = 3'd1,
    WR_ISSUE = 3'd2,
    WR_WAIT  = 3'd3,
    WR_DONE  = 3'd4
  } wr_state_t;

  localparam logic [7:0] RT_STAT_NONE    = 8'd0;
  localparam logic [7:0] RT_STAT_OK      = 8'd1;
  localparam logic [7:0] RT_STAT_TIMEOUT = 8'd2;

  // Destination of chunk idx; the 32-bit sum wraps silently.
  function automatic logic [31:0] chunk_addr(input logic [31:0] base, input logic [23:0] idx);
    return base + (32'(idx) << $clog2(CHUNK_BYTES));
  endfunction

endpackage

// File: rtl/rt_chunk_packer.sv
// Packs a stream of words into one chunk-wide buffer; slots not yet written
// read as zero so a partial chunk carries a clean tail.
module rt_chunk_packer #(
  parameter int WORD_W      = 32,
  parameter int CHUNK_WORDS = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic                          wr_i,
  input  logic [WORD_W-1:0]             data_i,
  output logic [$clog2(CHUNK_WORDS):0]  word_cnt_o,
  output logic                          last_slot_o,
  output logic [WORD_W*CHUNK_WORDS-1:0] chunk_o
);

  localparam int IDX_W = $clog2(CHUNK_WORDS);
  localparam logic [IDX_W:0] CNT_MAX  = (IDX_W+1)'(CHUNK_WORDS);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(CHUNK_WORDS - 1);

  logic [WORD_W-1:0] buf_q [CHUNK_WORDS];
  logic [IDX_W:0]    cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
      for (int i = 0; i < CHUNK_WORDS; i++) buf_q[i] <= '0;
    end else if (wr_i && (cnt_q < CNT_MAX)) begin
      buf_q[cnt_q[IDX_W-1:0]] <= data_i;
      cnt_q                   <= cnt_q + (IDX_W+1)'(1);
    end
  end

  always_comb begin
    chunk_o = '0;
    for (int i = 0; i < CHUNK_WORDS; i++) chunk_o[i*WORD_W +: WORD_W] = buf_q[i];
  end

  assign word_cnt_o  = cnt_q;
  assign last_slot_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/rt_result_writer.sv
// Raytracer result write-back: packs result words into chunks, hands each to
// the SDRAM write bridge at base + k*256, then reports frame status.
//
// state    | meaning
// IDLE     | waiting for cfg_start
// FILL     | accepting result words into the chunk buffer
// ISSUE    | one-cycle sdr_writestart for the packed chunk
// WAIT     | waiting for sdr_writeend, bounded by TIMEOUT
// DONE     | one-cycle end_rt pulse with final status
module rt_result_writer #(
  parameter int WORD_W      = rt_sdr_pkg::WORD_W,
  parameter int CHUNK_WORDS = rt_sdr_pkg::CHUNK_WORDS,
  parameter int TIMEOUT     = 1048576
) (
  input  logic                          sdr_clk,
  input  logic                          sdr_reset,
  input  logic                          cfg_start,
  input  logic [31:0]                   base_addr,
  input  logic                          res_valid,
  input  logic [WORD_W-1:0]             res_data,
  input  logic                          res_last,
  output logic                          res_ready,
  output logic [31:0]                   sdr_baseaddr,
  output logic [29:0]                   sdr_nelems,
  output logic [WORD_W*CHUNK_WORDS-1:0] sdr_writedata,
  output logic                          sdr_writestart,
  input  logic                          sdr_writeend,
  output logic                          end_rt,
  output logic [7:0]                    end_rtstat,
  output logic                          busy
);

  import rt_sdr_pkg::*;

  localparam int CNT_W = $clog2(CHUNK_WORDS) + 1;
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  wr_state_t         state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [23:0]       chunk_q, chunk_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        stat_q, stat_d;
  logic              last_q, last_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;

  logic              pk_clr, pk_wr, pk_last_slot;
  logic [CNT_W-1:0]  pk_cnt;
  logic [WORD_W*CHUNK_WORDS-1:0] pk_data;

  rt_chunk_packer #(
    .WORD_W      (WORD_W),
    .CHUNK_WORDS (CHUNK_WORDS)
  ) u_packer (
    .clk_i       (sdr_clk),
    .rst_i       (sdr_reset),
    .clr_i       (pk_clr),
    .wr_i        (pk_wr),
    .data_i      (res_data),
    .word_cnt_o  (pk_cnt),
    .last_slot_o (pk_last_slot),
    .chunk_o     (pk_data)
  );

  always_ff @(posedge sdr_clk) begin
    if (sdr_reset) begin
      state_q <= WR_IDLE;
      base_q  <= '0;
      chunk_q <= '0;
      addr_q  <= '0;
      stat_q  <= RT_STAT_NONE;
      last_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      chunk_q <= chunk_d;
      addr_q  <= addr_d;
      stat_q  <= stat_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    chunk_d = chunk_q;
    addr_d  = addr_q;
    stat_d  = stat_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    pk_clr  = 1'b0;
    pk_wr   = 1'b0;

    unique case (state_q)
      WR_IDLE: begin
        if (cfg_start) begin
          base_d  = base_addr;
          chunk_d = '0;
          stat_d  = RT_STAT_NONE;
          last_d  = 1'b0;
          pk_clr  = 1'b1;
          state_d = WR_FILL;
        end
      end
      WR_FILL: begin
        if (res_valid) begin
          pk_wr  = 1'b1;
          last_d = res_last;
          if (res_last || pk_last_slot) begin
            // Latch the destination now so it stays stable through WAIT.
            addr_d  = chunk_addr(base_q, chunk_q);
            state_d = WR_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        tcnt_d  = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (sdr_writeend) begin
          chunk_d = chunk_q + 24'd1;
          if (last_q) begin
            stat_d  = RT_STAT_OK;
            state_d = WR_DONE;
          end else begin
            pk_clr  = 1'b1;
            state_d = WR_FILL;
          end
        end else if (tcnt_q == TO_LAST) begin
          stat_d  = RT_STAT_TIMEOUT;
          state_d = WR_DONE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      WR_DONE: begin
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  assign res_ready      = (state_q == WR_FILL);
  assign busy           = (state_q != WR_IDLE);
  assign sdr_writestart = (state_q == WR_ISSUE);
  assign end_rt         = (state_q == WR_DONE);
  assign sdr_baseaddr   = addr_q;
  assign sdr_nelems     = 30'(pk_cnt);
  assign sdr_writedata  = pk_data;
  assign end_rtstat     = stat_q;

endmodule

// File: tb/tb_rt_result_writer.sv
// Bench for rt_result_writer: table of frame scenarios checked against a
// chunking model, plus directed sequences for reset, ignored strobes and timeout.
module tb_rt_result_writer;

  localparam int DW = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic [31:0] base_addr = '0;
  logic res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic res_last = 1'b0;
  logic we_bridge = 1'b0;
  logic we_manual = 1'b0;
  logic sdr_writeend;
  assign sdr_writeend = we_bridge | we_manual;

  logic res_ready, sdr_writestart, end_rt, busy;
  logic [31:0] sdr_baseaddr;
  logic [29:0] sdr_nelems;
  logic [DW-1:0] sdr_writedata;
  logic [7:0] end_rtstat;

  logic to_res_ready, to_writestart, to_end_rt, to_busy;
  logic [31:0] to_baseaddr;
  logic [29:0] to_nelems;
  logic [DW-1:0] to_writedata;
  logic [7:0] to_end_rtstat;

  rt_result_writer #(.WORD_W(32), .CHUNK_WORDS(64), .TIMEOUT(1024)) dut (
    .sdr_clk(clk), .sdr_reset(rst), .cfg_start(cfg_start), .base_addr(base_addr),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
    .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
    .sdr_writestart(sdr_writestart), .sdr_writeend(sdr_writeend), .end_rt(end_rt),
    .end_rtstat(end_rtstat), .busy(busy)
  );

  rt_result_writer #(.WORD_W(32), .CHUNK_WORDS(64), .TIMEOUT(16)) dut_to (
    .sdr_clk(clk), .sdr_reset(rst), .cfg_start(cfg_start), .base_addr(base_addr),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(to_res_ready),
    .sdr_baseaddr(to_baseaddr), .sdr_nelems(to_nelems), .sdr_writedata(to_writedata),
    .sdr_writestart(to_writestart), .sdr_writeend(sdr_writeend), .end_rt(to_end_rt),
    .end_rtstat(to_end_rtstat), .busy(to_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor on the main instance: records every issued chunk and handshake events.
  typedef struct {
    logic [31:0]   addr;
    logic [29:0]   n;
    logic [DW-1:0] data;
    int            c;
  } chunk_t;

  chunk_t chunks[$];
  chunk_t c_rec;
  int ws_cnt = 0, end_cnt = 0, end_c = 0, we_c = 0;
  int rdy_viol = 0, hold_viol = 0, resume_viol = 0;
  logic [7:0] end_stat = '0;
  bit in_wait = 1'b0, resume_chk = 1'b0;

  always @(negedge clk) begin
    if (resume_chk && !(res_ready || end_rt)) resume_viol++;
    resume_chk = 1'b0;
    if (sdr_writestart) begin
      ws_cnt++;
      c_rec.addr = sdr_baseaddr;
      c_rec.n    = sdr_nelems;
      c_rec.data = sdr_writedata;
      c_rec.c    = cyc;
      chunks.push_back(c_rec);
      in_wait = 1'b1;
      if (res_ready) rdy_viol++;
    end else if (in_wait) begin
      if (res_ready) rdy_viol++;
      if (sdr_writeend) begin
        if (sdr_baseaddr !== c_rec.addr || sdr_nelems !== c_rec.n || sdr_writedata !== c_rec.data)
          hold_viol++;
        in_wait    = 1'b0;
        resume_chk = 1'b1;
        we_c       = cyc;
      end
    end
    if (end_rt) begin
      end_cnt++;
      end_stat = end_rtstat;
      end_c    = cyc;
      in_wait  = 1'b0;
    end
    if (rst) begin
      in_wait    = 1'b0;
      resume_chk = 1'b0;
    end
  end

  // Bridge model: completes each write bridge_delay cycles after writestart.
  bit bridge_en = 1'b0;
  int bridge_delay = 1;
  initial forever begin
    @(negedge clk);
    if (bridge_en && sdr_writestart && !rst) begin
      repeat (bridge_delay) @(posedge clk);
      #1 we_bridge = 1'b1;
      @(posedge clk);
      #1 we_bridge = 1'b0;
    end
  end

  logic [31:0] words [0:255];
  int acc_cyc [0:255];

  task automatic send_frame(input int n, input int pct, input int glitch);
    int  i = 0;
    int  guard = 0;
    bit  v, acc;
    bit  glitched = 1'b0;
    while (i < n && guard < 20000) begin
      v = ($urandom_range(99) < pct);
      res_valid = v;
      res_data  = words[i];
      res_last  = (i == n - 1);
      if (i == glitch && !glitched) begin
        cfg_start = 1'b1;
        base_addr = 32'hDEAD_0000;
        glitched  = 1'b1;
      end
      @(negedge clk);
      acc = v && res_ready;
      if (acc) acc_cyc[i] = cyc;
      tick();
      cfg_start = 1'b0;
      if (acc) i++;
      guard++;
    end
    res_valid = 1'b0;
    res_last  = 1'b0;
    check("words accepted", 64'(i), 64'(n));
  endtask

  function automatic logic [DW-1:0] exp_data(input int k, input int n);
    logic [DW-1:0] d = '0;
    for (int j = 0; j < 64; j++)
      if (64*k + j < n) d[32*j +: 32] = words[64*k + j];
    return d;
  endfunction

  typedef struct {
    logic [31:0] base;
    int n;
    int pct;
    int delay;
    bit seq;
    int glitch;
    int exp_chunks;
    int exp_last_n;
  } vec_t;

  task automatic run_case(input vec_t v, input int idx);
    int c0, e0, rv0, hv0, sv0, got, guard, en, bad;
    logic [31:0] ea;
    logic [DW-1:0] ad, ed;
    for (int i = 0; i < v.n; i++) words[i] = v.seq ? 32'(i) : $urandom();
    bridge_en = 1'b1;
    bridge_delay = v.delay;
    c0 = chunks.size(); e0 = end_cnt; rv0 = rdy_viol; hv0 = hold_viol; sv0 = resume_viol;
    cfg_start = 1'b1;
    base_addr = v.base;
    tick();
    cfg_start = 1'b0;
    base_addr = $urandom();
    send_frame(v.n, v.pct, v.glitch);
    guard = 0;
    while (end_cnt == e0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("c%0d end_rt count", idx), 64'(end_cnt - e0), 64'd1);
    check($sformatf("c%0d end stat", idx), 64'(end_stat), 64'd1);
    check($sformatf("c%0d end latency", idx), 64'(end_c), 64'(we_c + 1));
    got = chunks.size() - c0;
    check($sformatf("c%0d chunk count", idx), 64'(got), 64'(v.exp_chunks));
    for (int k = 0; k < got && k < v.exp_chunks; k++) begin
      ea = v.base + 32'(k * 256);
      en = (v.n - 64*k > 64) ? 64 : v.n - 64*k;
      ad = chunks[c0 + k].data;
      ed = exp_data(k, v.n);
      check($sformatf("c%0d k%0d addr", idx, k), 64'(chunks[c0 + k].addr), 64'(ea));
      check($sformatf("c%0d k%0d nelems", idx, k), 64'(chunks[c0 + k].n), 64'(en));
      check($sformatf("c%0d k%0d issue latency", idx, k), 64'(chunks[c0 + k].c), 64'(acc_cyc[64*k + en - 1] + 1));
      bad = 0;
      for (int j = 63; j >= 0; j--) if (ad[32*j +: 32] !== ed[32*j +: 32]) bad = j;
      check($sformatf("c%0d k%0d data word%0d", idx, k, bad), 64'(ad[32*bad +: 32]), 64'(ed[32*bad +: 32]));
    end
    if (got > 0)
      check($sformatf("c%0d last nelems", idx), 64'(chunks[c0 + got - 1].n), 64'(v.exp_last_n));
    if (v.seq && got > 1)
      check($sformatf("c%0d chunk1 word0", idx), 64'(chunks[c0 + 1].data[31:0]), 64'd64);
    check($sformatf("c%0d ready in issue/wait", idx), 64'(rdy_viol - rv0), 64'd0);
    check($sformatf("c%0d held in wait", idx), 64'(hold_viol - hv0), 64'd0);
    check($sformatf("c%0d resume latency", idx), 64'(resume_viol - sv0), 64'd0);
    tick();
    @(negedge clk);
    check($sformatf("c%0d idle busy", idx), 64'(busy), 64'd0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " res_ready"}, 64'(res_ready), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " writestart"}, 64'(sdr_writestart), 64'd0);
    check({tag, " end_rt"}, 64'(end_rt), 64'd0);
    check({tag, " end_rtstat"}, 64'(end_rtstat), 64'd0);
    check({tag, " baseaddr"}, 64'(sdr_baseaddr), 64'd0);
    check({tag, " nelems"}, 64'(sdr_nelems), 64'd0);
    check({tag, " writedata nonzero"}, 64'(|sdr_writedata), 64'd0);
  endtask

  vec_t vecs[7];
  vec_t rv;
  int e0, w0, s, e;
  logic [7:0] st;

  initial begin
    vecs[0] = '{32'h0000_1000, 128, 100, 5,   1'b1, -1, 2, 64};
    vecs[1] = '{32'h0000_2000, 70,  100, 3,   1'b0, -1, 2, 6};
    vecs[2] = '{32'h0000_3000, 200, 30,  200, 1'b0, -1, 4, 8};
    vecs[3] = '{32'hFFFF_FF00, 65,  100, 2,   1'b0, -1, 2, 1};
    vecs[4] = '{32'h0000_5500, 63,  60,  7,   1'b0, 10, 1, 63};
    vecs[5] = '{32'h0004_0000, 1,   100, 1,   1'b0, -1, 1, 1};
    vecs[6] = '{32'h0000_6000, 64,  100, 4,   1'b0, 30, 1, 64};

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    for (int t = 0; t < 7; t++) run_case(vecs[t], t);

    // Single word; sdr_writeend during ISSUE must be ignored.
    bridge_en = 1'b0;
    w0 = ws_cnt;
    cfg_start = 1'b1;
    base_addr = 32'h0000_0400;
    tick();
    cfg_start = 1'b0;
    res_valid = 1'b1;
    res_data  = 32'hCAFE_0001;
    res_last  = 1'b1;
    @(negedge clk);
    check("sw ready in fill", 64'(res_ready), 64'd1);
    tick();
    res_valid = 1'b0;
    res_last  = 1'b0;
    we_manual = 1'b1;
    @(negedge clk);
    check("sw writestart", 64'(sdr_writestart), 64'd1);
    check("sw nelems", 64'(sdr_nelems), 64'd1);
    check("sw addr", 64'(sdr_baseaddr), 64'h400);
    check("sw word0", 64'(sdr_writedata[31:0]), 64'hCAFE_0001);
    check("sw word1", 64'(sdr_writedata[63:32]), 64'd0);
    tick();
    we_manual = 1'b0;
    @(negedge clk);
    check("sw writestart one cycle", 64'(sdr_writestart), 64'd0);
    check("sw still busy", 64'(busy), 64'd1);
    check("sw no end", 64'(end_rt), 64'd0);
    repeat (6) tick();
    @(negedge clk);
    check("sw waits", 64'(busy), 64'd1);
    check("sw no end later", 64'(end_rt), 64'd0);
    check("sw one writestart", 64'(ws_cnt - w0), 64'd1);
    tick();
    we_manual = 1'b1;
    tick();
    we_manual = 1'b0;
    @(negedge clk);
    check("sw end_rt", 64'(end_rt), 64'd1);
    check("sw stat", 64'(end_rtstat), 64'd1);
    tick();
    @(negedge clk);
    check("sw idle", 64'(busy), 64'd0);
    check("sw stat held", 64'(end_rtstat), 64'd1);
    tick();

    // Reset while a write is in flight.
    for (int i = 0; i < 3; i++) words[i] = $urandom();
    cfg_start = 1'b1;
    base_addr = 32'h0000_8000;
    tick();
    cfg_start = 1'b0;
    send_frame(3, 100, -1);
    tick();
    tick();
    e0 = end_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst in wait");
    tick();
    repeat (20) tick();
    check("rst no end_rt", 64'(end_cnt - e0), 64'd0);
    rv = '{32'h0000_9000, 10, 100, 2, 1'b0, 3, 1, 10};
    run_case(rv, 100);

    // Timeout on the short-timeout instance; bridge stays silent.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bridge_en = 1'b0;
    cfg_start = 1'b1;
    base_addr = 32'h0000_A000;
    tick();
    cfg_start = 1'b0;
    res_valid = 1'b1;
    res_data  = 32'h1234_5678;
    res_last  = 1'b1;
    tick();
    res_valid = 1'b0;
    res_last  = 1'b0;
    s = -1000;
    e = -1;
    st = '0;
    for (int g = 0; g < 100 && e < 0; g++) begin
      @(negedge clk);
      if (to_writestart) s = cyc;
      if (to_end_rt) begin
        e  = cyc;
        st = to_end_rtstat;
      end
    end
    check("timeout wait cycles", 64'(e - (s + 1)), 64'd16);
    check("timeout stat", 64'(st), 64'd2);
    tick();
    @(negedge clk);
    check("timeout idle busy", 64'(to_busy), 64'd0);
    check("timeout single pulse", 64'(to_end_rt), 64'd0);
    check("timeout stat held", 64'(to_end_rtstat), 64'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
